sccb_config_sequencer: RTL and testbench
========================================

# sccb_config_sequencer

Table-driven SCCB register-programming sequencer; parametrised successor of the camera config FSM. Walks a synchronous config ROM of typed entries (write, delay, end; optional write-verify), drives an SCCB transaction engine through a start/done handshake, retries NACKed transfers and reports completion or a located error. Sits between the config ROM and the SCCB engine in the camera init path; supports 8- or 16-bit register addresses and restart on request.

## Interface
- CLK_FREQ, 25_000_000, clock frequency in Hz
- REG_ADDR_W, 8, register address width; 8 or 16 only
- DATA_W, 8, register data width
- ROM_ADDR_W, 8, config ROM address width
- DELAY_UNIT_US, 1000, microseconds per delay count
- MAX_RETRIES, 3, retries per entry after the first NACK; 0 disables retry
- AUTO_START, 1, begin the sequence automatically after reset
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; (re)run table from entry 0; ignored while busy
- rom_addr  out  ROM_ADDR_W  ROM address, registered
- rom_data  in  2+REG_ADDR_W+DATA_W  entry {op[1:0], addr, data}, valid 1 cycle after rom_addr
- sccb_ready  in  1  engine idle
- sccb_start  out  1  one-cycle transaction request
- sccb_rw  out  1  0 write, 1 read
- sccb_addr  out  REG_ADDR_W  register address
- sccb_wdata  out  DATA_W  write data
- sccb_rdata  in  DATA_W  read data, valid with sccb_done
- sccb_done  in  1  one-cycle transaction complete
- sccb_nack  in  1  qualifies sccb_done; slave did not acknowledge
- busy  out  1  sequence in progress
- done  out  1  sticky; table completed without error
- error  out  1  sticky; sequence aborted
- err_code  out  2  0 none, 1 NACK exhausted, 2 table overrun, 3 verify mismatch
- err_index  out  ROM_ADDR_W  entry index of the failure

## Operation
- Opcodes: WRITE=0, DELAY=1, VERIFY=2, END=3.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, RDISSUE, RDWAIT, DONE, ERROR.
- IDLE -> FETCH on start, or on the first cycle after reset when AUTO_START=1. Entry clears done/error/err_code/err_index/retry count and sets rom_addr=0.
- FETCH: one-cycle wait for ROM latency -> DECODE.
- DECODE: END -> DONE. DELAY -> DELAY with counter = {addr,data} * (CLK_FREQ/1_000_000*DELAY_UNIT_US); a zero field skips straight to the next entry. WRITE/VERIFY -> ISSUE.
- ISSUE: when sccb_ready=1, pulse sccb_start with sccb_rw=0 and the entry's addr/data latched -> WAIT. Hold while ready=0.
- WAIT: on sccb_done with nack=0, WRITE advances; VERIFY -> RDISSUE. With nack=1, retry count < MAX_RETRIES -> increment, back to ISSUE. Otherwise -> ERROR with code 1.
- RDISSUE/RDWAIT: same handshake with sccb_rw=1. A NACK follows the same retry rule, restarting at ISSUE. sccb_rdata != data -> ERROR with code 3.
- Advance: retry count cleared. If rom_addr == 2^ROM_ADDR_W-1 -> ERROR with code 2 (no wrap); else rom_addr+1 -> FETCH.
- DONE/ERROR: set the sticky flag -> IDLE; busy=0. err_index = rom_addr of the failing entry.
- start asserted in the same cycle as a DONE/ERROR transition is ignored; a new start is accepted in IDLE.

## Timing
- All outputs reset to 0; state=IDLE; busy is combinational (state != IDLE).
- sccb_start is high exactly one cycle, never while sccb_ready=0. Max one outstanding transaction.
- WRITE entry minimum cost: FETCH+DECODE+ISSUE = 3 cycles plus engine time.
- A delay of N units holds DELAY for N*CLK_FREQ/1e6*DELAY_UNIT_US cycles ±1. Counter width is sized at elaboration for a field value of all ones.
- reset_n low mid-transaction aborts immediately. The engine is reset on the same net.

## Configuration
- SCCB_CFG_VERIFY_EN defined: VERIFY opcode, RDISSUE/RDWAIT and err_code 3 are present.
- Undefined: opcode 2 behaves as WRITE; the RD states are absent; sccb_rw is tied 0; sccb_rdata is unused.

## Structure
- Package sccb_cfg_pkg holds the opcode enum, state_t, the err_code enum and the clocks-per-unit function.
- Sub-module sccb_cfg_delay holds the loadable down-counter with a zero flag, parametrised by width.

## Test plan
- Table {W 0x12=0x80, W 0x11=0x01, END}, engine always ACKs -> two writes in order, done=1 and error=0 after the third fetch.
- CLK_FREQ=1_000_000, DELAY_UNIT_US=10, DELAY field 3 -> 30±1 cycles between surrounding sccb_start pulses.
- MAX_RETRIES=2, NACK on entry 1 three times -> 3 starts to the same address, then error=1, err_code=1, err_index=1.
- With VERIFY_EN, VERIFY 0x3A=0x04, readback 0x05 -> err_code=3, err_index at that entry. Readback 0x04 -> advance.
- ROM_ADDR_W=2, no END in 4 entries -> err_code=2, err_index=3, rom_addr does not wrap.
- REG_ADDR_W=16 table mid-DELAY, reset_n pulsed low -> all outputs 0. With AUTO_START, the sequence reruns from entry 0. start during busy has no effect.

Source files
------------

// File: rtl/sccb_cfg_pkg.sv
// sccb_cfg_pkg: opcodes, FSM states, error codes and delay scaling for the SCCB config sequencer
package sccb_cfg_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_DELAY = 2'd1, OP_VERIFY = 2'd2, OP_END = 2'd3} op_t;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_RDISSUE, S_RDWAIT, S_DONE, S_ERROR
  } state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_NACK = 2'd1, ERR_OVERRUN = 2'd2, ERR_VERIFY = 2'd3} err_t;
  function automatic int clocks_per_unit(input int clk_freq, input int unit_us);
    return clk_freq / 1_000_000 * unit_us;
  endfunction
endpackage

// File: rtl/sccb_cfg_if.sv
// sccb_cfg_if: start/done handshake between the config sequencer (master) and the SCCB engine (slave)
interface sccb_cfg_if #(
  parameter int REG_ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic ready, start, rw, done, nack;
  logic [REG_ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master(input ready, rdata, done, nack, output start, rw, addr, wdata);
  modport slave(output ready, rdata, done, nack, input start, rw, addr, wdata);
endinterface

// File: rtl/sccb_cfg_delay.sv
// sccb_cfg_delay: loadable down-counter that stops at zero and flags it
module sccb_cfg_delay #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= load ? value : zero ? cnt : cnt - W'(1);
endmodule

// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer: walks a config ROM driving an SCCB engine; SCCB_CFG_VERIFY_EN adds write-verify
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int REG_ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ROM_ADDR_W = 8,
  parameter int DELAY_UNIT_US = 1000,
  parameter int MAX_RETRIES = 3,
  parameter int AUTO_START = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  output logic [ROM_ADDR_W-1:0]            rom_addr,
  input  logic [2+REG_ADDR_W+DATA_W-1:0]   rom_data,
  sccb_cfg_if.master                       sccb,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       err_code,
  output logic [ROM_ADDR_W-1:0]            err_index
);
  localparam int FW = REG_ADDR_W + DATA_W;
  localparam int CPU = clocks_per_unit(CLK_FREQ, DELAY_UNIT_US);
  localparam int CW = FW + $clog2(CPU + 1);
  localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  state_t state, state_d;
  op_t op;
  err_t code_d;
  logic [RW-1:0] retries;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0] dly_val;
  logic auto_q, go, adv, retry, fail, fin, latch, dly_load, dly_zero, last, can_retry, verify_q;
  assign op = op_t'(rom_data[FW+1:FW]);
  assign dly_val = CW'(rom_data[FW-1:0]) * CW'(CPU);
  assign last = &rom_addr;
  assign can_retry = int'(retries) < MAX_RETRIES;
  assign busy = state != S_IDLE;
  assign sccb.addr = addr_q;
  assign sccb.wdata = data_q;
`ifdef SCCB_CFG_VERIFY_EN
  assign sccb.start = (state == S_ISSUE || state == S_RDISSUE) && sccb.ready;
  assign sccb.rw = state == S_RDISSUE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) verify_q <= 1'b0;
    else if (latch) verify_q <= op == OP_VERIFY;
`else
  assign sccb.start = state == S_ISSUE && sccb.ready;
  assign sccb.rw = 1'b0;
  assign verify_q = 1'b0;
`endif
  always_comb begin
    state_d = state;
    {go, adv, retry, fail, fin, latch, dly_load} = '0;
    code_d = ERR_NONE;
    case (state)
      S_IDLE: begin
        go = start || auto_q;
        state_d = go ? S_FETCH : S_IDLE;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        latch = 1'b1;
        fin = op == OP_END;
        dly_load = op == OP_DELAY;
        adv = dly_load && dly_val == '0;
        state_d = fin ? S_DONE : dly_load ? S_DELAY : S_ISSUE;
      end
      S_ISSUE: state_d = sccb.ready ? S_WAIT : S_ISSUE;
      S_WAIT: if (sccb.done) begin
        retry = sccb.nack && can_retry;
        fail = sccb.nack && !can_retry;
        code_d = ERR_NACK;
        adv = !sccb.nack && !verify_q;
        state_d = sccb.nack ? S_ISSUE : S_RDISSUE;
      end
`ifdef SCCB_CFG_VERIFY_EN
      S_RDISSUE: state_d = sccb.ready ? S_RDWAIT : S_RDISSUE;
      S_RDWAIT: if (sccb.done) begin
        retry = sccb.nack && can_retry;
        fail = sccb.nack ? !can_retry : sccb.rdata != data_q;
        code_d = sccb.nack ? ERR_NACK : ERR_VERIFY;
        adv = !sccb.nack && sccb.rdata == data_q;
        state_d = S_ISSUE;
      end
`endif
      S_DELAY: adv = dly_zero;
      default: state_d = S_IDLE;
    endcase
    if (adv && last) begin
      fail = 1'b1;
      code_d = ERR_OVERRUN;
    end
    if (adv && !last) state_d = S_FETCH;
    if (fail) state_d = S_ERROR;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      auto_q <= 1'(AUTO_START);
      {rom_addr, retries, addr_q, data_q, done, error, err_code, err_index} <= '0;
    end else begin
      state <= state_d;
      auto_q <= 1'b0;
      if (go) {rom_addr, retries, done, error, err_code, err_index} <= '0;
      if (adv && !last) rom_addr <= rom_addr + ROM_ADDR_W'(1);
      if (adv) retries <= '0;
      if (retry) retries <= retries + RW'(1);
      if (latch) {addr_q, data_q} <= rom_data[FW-1:0];
      if (fin) done <= 1'b1;
      if (fail) begin
        error <= 1'b1;
        err_code <= code_d;
        err_index <= rom_addr;
      end
    end
  sccb_cfg_delay #(.W(CW)) u_delay (
    .clk(clk), .reset_n(reset_n), .load(dly_load), .value(dly_val), .zero(dly_zero)
  );
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer: random config tables against a table-walking reference model plus directed corner cases
`timescale 1ns/1ps
module tb_sccb_config_sequencer;
  localparam int AW = 16, DW = 8, RA = 3, MAXR = 2;
  localparam int EW = 2 + AW + DW;
`ifdef SCCB_CFG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [RA-1:0] rom_addr, err_index;
  logic [EW-1:0] rom_data;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [EW-1:0] rom [8];
  logic nack_tab [64];
  logic [DW-1:0] xm_tab [64];
  logic [AW+DW:0] log_q [$], exp_q [$];
  int t_q [$];
  int cyc = 0, k_eng = 0, fix_lat = -1, n_cmp = 0, n_bad = 0;
  int exp_code, exp_idx;
  bit exp_done;

  sccb_cfg_if #(.REG_ADDR_W(AW), .DATA_W(DW)) sif();
  sccb_config_sequencer #(
    .CLK_FREQ(1_000_000), .REG_ADDR_W(AW), .DATA_W(DW), .ROM_ADDR_W(RA),
    .DELAY_UNIT_US(10), .MAX_RETRIES(MAXR), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb(sif), .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin : engine
    int lat;
    logic n;
    logic [DW-1:0] x;
    sif.ready = 1'b1; sif.done = 1'b0; sif.nack = 1'b0; sif.rdata = '0;
    forever begin
      @(negedge clk);
      if (sif.start) begin
        log_q.push_back({sif.rw, sif.addr, sif.wdata});
        t_q.push_back(cyc);
        n = nack_tab[k_eng % 64];
        x = sif.rw ? xm_tab[k_eng % 64] : '0;
        k_eng++;
        lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(3));
        @(posedge clk); #1;
        sif.ready = 1'b0;
        repeat (lat) begin @(posedge clk); #1; end
        sif.done = 1'b1; sif.nack = n; sif.rdata = sif.wdata ^ x;
        @(posedge clk); #1;
        sif.done = 1'b0; sif.nack = 1'b0; sif.ready = 1'b1;
      end
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {op, a, d};
  endfunction

  task automatic clr();
    for (int i = 0; i < 8; i++) rom[i] = ent(2'd3, 16'h0, 8'h0);
    for (int i = 0; i < 64; i++) begin nack_tab[i] = 1'b0; xm_tab[i] = '0; end
  endtask

  // Expected transactions and outcome, derived by walking the table under the retry rules
  task automatic predict();
    int i, k, r;
    bit fin, more, bad;
    logic [1:0] op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    i = 0; k = 0; fin = 0;
    exp_q.delete(); exp_code = 0; exp_idx = 0; exp_done = 0;
    while (!fin) begin
      {op, a, d} = rom[i];
      if (op == 2'd3) begin
        exp_done = 1; fin = 1;
      end else if (op != 2'd1) begin
        r = 0; more = 1;
        while (more) begin
          exp_q.push_back({1'b0, a, d});
          bad = nack_tab[k]; k++;
          if (!bad && op == 2'd2 && VERIFY) begin
            exp_q.push_back({1'b1, a, d});
            bad = nack_tab[k];
            if (!bad && xm_tab[k] != 0) begin exp_code = 3; exp_idx = i; fin = 1; more = 0; end
            k++;
          end
          if (!fin) begin
            if (!bad) more = 0;
            else if (r < MAXR) r++;
            else begin exp_code = 1; exp_idx = i; fin = 1; more = 0; end
          end
        end
      end
      if (!fin) begin
        if (i == 2**RA - 1) begin exp_code = 2; exp_idx = i; fin = 1; end
        else i++;
      end
    end
  endtask

  task automatic run(input bit by_reset, input bit poke);
    int n;
    predict();
    log_q.delete(); t_q.delete(); k_eng = 0;
    if (by_reset) begin
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk);
      check("reset_outputs", {busy, done, error, err_code, err_index, rom_addr, sif.start}, 0);
      reset_n = 1'b1;
    end else begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (!busy && n < 4) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 3000) begin
      start = poke && n == 3;
      @(negedge clk); n++;
    end
    start = 1'b0;
    check("finished", busy, 0);
    check("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) check($sformatf("txn%0d", i), log_q[i], exp_q[i]);
    check("done", done, exp_done);
    check("error", error, exp_code != 0);
    check("err_code", err_code, exp_code);
    check("err_index", err_index, exp_code != 0 ? exp_idx : 0);
  endtask

  initial begin
    int ga, gb, d, n, r;
    clr();
    rom[0] = ent(2'd0, 16'h12, 8'h80);
    rom[1] = ent(2'd0, 16'h11, 8'h01);
    run(1'b1, 1'b0);
    check("tp1_first", log_q[0], {1'b0, 16'h12, 8'h80});
    check("tp1_second", log_q[1], {1'b0, 16'h11, 8'h01});
    check("tp1_done", {done, error}, 2'b10);

    clr();
    rom[0] = ent(2'd0, 16'h20, 8'h01);
    rom[1] = ent(2'd0, 16'h21, 8'h02);
    nack_tab[1] = 1'b1; nack_tab[2] = 1'b1; nack_tab[3] = 1'b1;
    run(1'b0, 1'b0);
    check("nack_starts", log_q.size(), 4);
    check("nack_code", err_code, 1);
    check("nack_index", err_index, 1);

`ifdef SCCB_CFG_VERIFY_EN
    clr();
    rom[0] = ent(2'd0, 16'h10, 8'h01);
    rom[1] = ent(2'd2, 16'h3A, 8'h04);
    xm_tab[2] = 8'h01;
    run(1'b0, 1'b0);
    check("verify_bad_code", err_code, 3);
    check("verify_bad_index", err_index, 1);
    xm_tab[2] = 8'h00;
    run(1'b0, 1'b0);
    check("verify_ok_done", {done, error}, 2'b10);
`else
    clr();
    rom[0] = ent(2'd2, 16'h3A, 8'h04);
    run(1'b0, 1'b0);
    check("op2_as_write", log_q[0], {1'b0, 16'h3A, 8'h04});
    check("op2_done", {done, error}, 2'b10);
`endif

    clr();
    for (int i = 0; i < 8; i++) rom[i] = ent(2'd0, 16'(16'h40 + i), 8'(i));
    run(1'b0, 1'b0);
    check("overrun_code", err_code, 2);
    check("overrun_index", err_index, 7);
    check("overrun_no_wrap", rom_addr, 7);

    clr();
    fix_lat = 2;
    rom[0] = ent(2'd0, 16'h0001, 8'h11);
    rom[1] = ent(2'd0, 16'h0002, 8'h22);
    run(1'b0, 1'b0);
    ga = t_q[1] - t_q[0];
    rom[1] = ent(2'd1, 16'h0000, 8'h03);
    rom[2] = ent(2'd0, 16'h0002, 8'h22);
    run(1'b0, 1'b0);
    gb = t_q[1] - t_q[0];
    d = gb - ga;
    check("delay_cost", (d >= 31 && d <= 33) ? 32 : d, 32);

    predict();
    log_q.delete(); t_q.delete(); k_eng = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (log_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("busy_mid_delay", busy, 1);
    run(1'b1, 1'b0);
    check("rerun_entry0", log_q[0], {1'b0, 16'h0001, 8'h11});
    run(1'b0, 1'b1);
    fix_lat = -1;

    for (int t = 0; t < 40; t++) begin
      clr();
      for (int j = 0; j < 8; j++) begin
        r = int'($urandom_range(99));
        rom[j] = r < 40 ? ent(2'd0, 16'($urandom), 8'($urandom)) :
                 r < 65 ? ent(2'd2, 16'($urandom), 8'($urandom)) :
                 r < 80 ? ent(2'd1, 16'h0, 8'($urandom_range(3))) : ent(2'd3, 16'h0, 8'h0);
      end
      for (int j = 0; j < 64; j++) begin
        nack_tab[j] = $urandom_range(99) < 25;
        xm_tab[j] = $urandom_range(99) < 15 ? 8'($urandom_range(255, 1)) : 8'h00;
      end
      run($urandom_range(3) == 0, $urandom_range(1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
